// File: rtl/arb8_hold.sv
// arb8_hold: 8-way arbiter, fixed or round-robin, with held grants.
// Grant persists until release, owner request drop, or hold timeout.
module arb8_hold #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            rel,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HCW = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [N-1:0]   ONE       = N'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic [HCW-1:0]  hold_cnt;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] fix_idx;
    logic [IDXW-1:0] rr_idx;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] win;
    logic            owner_req;

    // Fixed: ascending scan so the highest set bit wins.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) fix_idx = IDXW'(i);
        end
    end

    // Round-robin: scan from the far end of the order so the
    // candidate closest below last_idx is assigned last and wins.
    always_comb begin
        rr_idx = '0;
        cand   = '0;
        for (int k = N; k >= 1; k--) begin
            cand = last_idx - IDXW'(k);
            if (req[cand]) rr_idx = cand;
        end
    end

    assign win       = mode ? rr_idx : fix_idx;
    assign owner_req = req[gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            last_idx  <= '0;
            hold_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state     <= BUSY;
                        gnt       <= ONE << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        last_idx  <= win;
                    end
                end
                BUSY: begin
                    if (rel || !owner_req) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_hold.sv
// tb_arb8_hold: directed and random checks of arb8_hold
// against a cycle-level behavioural model.
module tb_arb8_hold;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       rel = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors = 0;
    int errors  = 0;

    // model state: owner = -1 means no grant
    int m_owner = -1;
    int m_idx   = 0;
    int m_last  = 0;
    int m_held  = 0;
    int m_to    = 0;

    arb8_hold #(.N(8), .IDXW(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .rel(rel),
        .mode(mode),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic m,
                                input int last);
        int w;
        w = -1;
        if (!m) begin
            for (int i = 7; i >= 0; i--)
                if (w < 0 && r[i]) w = i;
        end else begin
            for (int k = 1; k <= 8; k++)
                if (w < 0 && r[(last - k + 8) % 8]) w = (last - k + 8) % 8;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_idx   = 0;
        m_last  = 0;
        m_held  = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl,
                              input logic m);
        m_to = 0;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = pick(r, m, m_last);
                m_idx   = m_owner;
                m_last  = m_owner;
                m_held  = 1;
            end
        end else if (rl || !r[m_owner]) begin
            m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // called at negedge; applies inputs across one posedge
    task automatic step(input logic [7:0] r, input logic rl,
                        input logic m);
        req  = r;
        rel  = rl;
        mode = m;
        model_step(r, rl, m);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [7:0] rr;
        logic       rm;
        int         seg;
        int         relp;
        int         vcnt;

        @(negedge clk);
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_idx", 32'(gnt_idx), 32'h0);

        // fixed priority
        step(8'b0010_0110, 1'b0, 1'b0);
        chk("fix_idx5", 32'(gnt_idx), 32'd5);
        chk("fix_gnt5", 32'(gnt), 32'h20);
        step(8'b0000_0110, 1'b1, 1'b0);
        chk("fix_rel", 32'(gnt), 32'h0);
        step(8'b0000_0110, 1'b0, 1'b0);
        chk("fix_idx2", 32'(gnt_idx), 32'd2);

        // round-robin fairness
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            chk("rr_seq", 32'(gnt_idx), 32'((15 - i) % 8));
            step(8'hFF, 1'b1, 1'b1);
            chk("rr_gap", 32'(gnt_valid), 32'd0);
        end

        // timeout
        do_reset();
        vcnt = 0;
        for (int i = 0; i < MAX_HOLD + 1; i++) begin
            step(8'h01, 1'b0, 1'b0);
            if (gnt_valid) vcnt++;
        end
        chk("to_len", 32'(vcnt), 32'(MAX_HOLD));
        chk("to_pulse", 32'(timeout), 32'd1);
        step(8'h01, 1'b0, 1'b0);
        chk("to_regrant", 32'(gnt), 32'h01);
        chk("to_clear", 32'(timeout), 32'd0);

        // owner drops request
        do_reset();
        step(8'h48, 1'b0, 1'b0);
        step(8'h48, 1'b1, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        chk("drop_own3", 32'(gnt_idx), 32'd3);
        step(8'h40, 1'b0, 1'b0);
        chk("drop_gnt", 32'(gnt), 32'h0);
        step(8'h40, 1'b0, 1'b0);
        chk("drop_idx6", 32'(gnt_idx), 32'd6);
        chk("drop_to", 32'(timeout), 32'd0);

        // release on the timeout edge
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        chk("relto_to", 32'(timeout), 32'd0);
        chk("relto_v", 32'(gnt_valid), 32'd0);

        // async reset mid-grant
        do_reset();
        step(8'h10, 1'b0, 1'b0);
        chk("ar_pre", 32'(gnt), 32'h10);
        #1 rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_valid", 32'(gnt_valid), 32'd0);
        chk("ar_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(8'h81, 1'b0, 1'b1);
        chk("ar_rr7", 32'(gnt_idx), 32'd7);

        // random segments
        do_reset();
        for (int s = 0; s < 150; s++) begin
            rr   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 8'h00;
            rm   = 1'($urandom);
            seg  = $urandom_range(1, 40);
            relp = $urandom_range(0, 2) == 0 ? 0 : 6;
            for (int c = 0; c < seg; c++) begin
                if ($urandom_range(0, 19) == 0) rr = 8'($urandom);
                step(rr, relp != 0 && $urandom_range(1, relp) == 1, rm);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/arb8_hold.md
Name: arb8_hold

Overview:
- 8-requester arbiter that shares one downstream resource among agents, using the team's 8-bit priority-encoding order.
- Selectable fixed-priority (bit 7 highest) or round-robin mode.
- Registered one-hot grant plus encoded index.
- Grant held until the owner releases, the owner drops its request, or a hold-timeout expires.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDXW, 3, width of grant index, equal to $clog2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held; legal range 2 to 255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector, bit i from requester i; level-sensitive.
- rel  input  1  release strobe from the current owner; ignored in IDLE.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- gnt_idx  output  3  encoded index of the current owner, registered; holds last value when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

Behaviour:
- Reset (async assert): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, last_idx=0, hold_cnt=0.
- Reset deassertion is synchronous to clk. Reset mid-grant drops gnt immediately.
- States: IDLE, BUSY.
- IDLE with req != 0 at edge t:
  - At t+1: state=BUSY, gnt=onehot(w), gnt_idx=w, gnt_valid=1, hold_cnt=0, last_idx=w.
  - Request-to-grant latency is 1 cycle.
- IDLE with req == 0: remain in IDLE, outputs unchanged (gnt=0).
- Fixed mode: w is the highest set bit of req.
- Round-robin mode:
  - Search order is last_idx-1, last_idx-2, ..., wrapping modulo 8, ending at last_idx. w is the first set bit in that order.
  - After reset (last_idx=0) the search starts at 7, so the first round-robin grant equals the fixed-priority result.
- BUSY, evaluated each edge in priority order:
  - (a) rel=1 OR req[gnt_idx]=0: release. Next cycle state=IDLE, gnt=0, gnt_valid=0, timeout=0.
  - (b) hold_cnt == MAX_HOLD-1: forced release. Next cycle state=IDLE, gnt=0, gnt_valid=0, timeout=1 for exactly one cycle.
  - (c) otherwise: hold_cnt increments, grant unchanged.
- A grant is therefore visible for at most MAX_HOLD cycles.
- If (a) and (b) hit on the same edge, (a) wins and timeout stays 0.
- Every release produces exactly one IDLE cycle, so there is no back-to-back grant; the minimum gap between grants is 1 cycle.
- Requests from non-owners during BUSY are ignored; they are arbitrated at the next IDLE cycle.
- A requester that times out but keeps req high is eligible again. In round-robin mode it is lowest priority; in fixed mode it can win again.
- hold_cnt width is $clog2(MAX_HOLD) bits. The counter never wraps, because the compare happens before increment.
- gnt is always one-hot or zero, and gnt == (gnt_valid ? 1<<gnt_idx : 0).
- X on req while in BUSY must not affect gnt.

Test Plan:
- Fixed priority: mode=0, req=8'b0010_0110 -> gnt=8'b0010_0000, gnt_idx=5 one cycle later; rel=1 -> gnt=0 next cycle, then IDLE for 1 cycle, then gnt_idx=2 if req=8'b0000_0110.
- Round-robin fairness: mode=1, req=8'hFF held; owner pulses rel after 1 cycle each grant -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 with one idle cycle between grants.
- Timeout: MAX_HOLD=16, req=8'h01 held, rel=0 -> gnt_valid high for exactly 16 cycles; timeout=1 on the following cycle only; regrant to index 0 one cycle after that.
- Owner drops request: grant idx 3, deassert req[3] while req[6]=1 -> gnt=0 next cycle, gnt_idx=6 the cycle after; timeout stays 0.
- Release on the timeout edge: rel=1 exactly at hold_cnt=15 -> release with timeout=0.
- Async reset mid-grant: assert rst between edges while gnt=8'h10 -> gnt, gnt_valid, gnt_idx go to 0 immediately without waiting for a clock edge; after deassertion with mode=1, req=8'h81 -> gnt_idx=7 (last_idx reset to 0).
